// File: rtl/exec_ctrl.sv
`timescale 1ns/1ps
// exec_ctrl: run/halt/single-step sequencer for the processor datapath.
// Decides on which clk cycles the PC may advance and the register file may
// write, so the whole core runs on a single free-running clock.
//
// Ports:
//   clk        system clock
//   Reset      synchronous, active-high reset
//   StepKey    raw step pushbutton, active-low, asynchronous to clk
//   RunSw      1 = run continuously, 0 = halt/step mode (quasi-static)
//   BrkEn      breakpoint enable
//   BrkAddr    breakpoint PC address
//   Adds       current PC value
//   WEin       register write enable from the decoder
//   PCEn       PC advance enable, one-cycle pulse per instruction
//   WEout      gated register write enable (WEin & PCEn)
//   State      00 HALT, 01 RUN, 10 STEP, 11 BREAK
//   Halted     1 in HALT or BREAK
//   InstCount  retired instruction count (wraps)
module exec_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int RUN_DIV    = 4,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              StepKey,
    input  logic              RunSw,
    input  logic              BrkEn,
    input  logic [ADDR_W-1:0] BrkAddr,
    input  logic [ADDR_W-1:0] Adds,
    input  logic              WEin,
    output logic              PCEn,
    output logic              WEout,
    output logic [1:0]        State,
    output logic              Halted,
    output logic [15:0]       InstCount
);

    localparam int             DCW      = $clog2(DEB_CYCLES + 1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
    localparam logic [15:0]    DIV_LAST = 16'(RUN_DIV - 1);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10,
        S_BRK  = 2'b11
    } state_t;

    state_t         r_state, w_next;
    logic           r_sync1, r_sync2;
    logic           r_deb_lvl, r_deb_prev;
    logic [DCW-1:0] r_deb_cnt;
    logic [1:0]     r_fill;
    logic           r_armed;
    logic [15:0]    r_div;
    logic [15:0]    r_inst;
    logic           w_press, w_brk_hit, w_issue_pt, w_pcen;

    // Step key conditioning. r_fill marks when the synchroniser holds real
    // samples again after reset. r_armed blocks press events until the key
    // has been seen released, so a key held through reset cannot step.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_deb_lvl  <= 1'b1;
            r_deb_prev <= 1'b1;
            r_deb_cnt  <= '0;
            r_fill     <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_sync1    <= StepKey;
            r_sync2    <= r_sync1;
            r_deb_prev <= r_deb_lvl;
            r_fill     <= {r_fill[0], 1'b1};
            if (r_sync2 != r_deb_lvl) begin
                if (r_deb_cnt == DEB_LAST) begin
                    r_deb_lvl <= r_sync2;
                    r_deb_cnt <= '0;
                end else begin
                    r_deb_cnt <= r_deb_cnt + DCW'(1);
                end
            end else begin
                r_deb_cnt <= '0;
            end
            if (r_fill[1] && r_sync2 && r_deb_lvl)
                r_armed <= 1'b1;
        end
    end

    assign w_press    = r_armed & r_deb_prev & ~r_deb_lvl;
    assign w_brk_hit  = BrkEn && (Adds == BrkAddr);
    assign w_issue_pt = (r_div == DIV_LAST);

    // A breakpoint suppresses the issue itself; STEP ignores it so stepping
    // out of BREAK executes the breakpointed instruction once.
    assign w_pcen = (r_state == S_STEP) ||
                    ((r_state == S_RUN) && RunSw && w_issue_pt && !w_brk_hit);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_HALT: begin
                if (RunSw)        w_next = S_RUN;
                else if (w_press) w_next = S_STEP;
            end
            S_RUN: begin
                if (!RunSw)                      w_next = S_HALT;
                else if (w_issue_pt && w_brk_hit) w_next = S_BRK;
            end
            S_STEP: w_next = S_HALT;
            S_BRK: begin
                if (!RunSw)       w_next = S_HALT;
                else if (w_press) w_next = S_STEP;
            end
            default: w_next = S_HALT;
        endcase
    end

    // Divider only advances while running; any other state parks it at 0,
    // so each RUN entry starts a fresh issue period.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state <= S_HALT;
            r_div   <= '0;
            r_inst  <= '0;
        end else begin
            r_state <= w_next;
            r_inst  <= r_inst + 16'(w_pcen);
            if ((r_state == S_RUN) && RunSw)
                r_div <= w_issue_pt ? 16'd0 : r_div + 16'd1;
            else
                r_div <= '0;
        end
    end

    assign PCEn      = w_pcen;
    assign WEout     = WEin & w_pcen;
    assign State     = r_state;
    assign Halted    = (r_state == S_HALT) || (r_state == S_BRK);
    assign InstCount = r_inst;

endmodule

// File: tb/tb_exec_ctrl.sv
`timescale 1ns/1ps
module tb_exec_ctrl;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             StepKey = 1'b1;
    logic             RunSw = 1'b0;
    logic             BrkEn = 1'b0;
    logic             WEin = 1'b0;
    logic [15:0]      BrkAddr = 16'h0;
    logic [15:0]      Adds = 16'h0;
    logic [2:0]       pcen, we, halt;
    logic [2:0][1:0]  st;
    logic [2:0][15:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: run/halt mode plus cycles since RUN entry per DUT.
    bit m_run [3];
    int m_age [3];
    int m_cnt [3];

    always #5 clk = ~clk;

    exec_ctrl #(.DEB_CYCLES(16), .RUN_DIV(4), .ADDR_W(16)) u_d4 (
        .clk(clk), .Reset(Reset), .StepKey(StepKey), .RunSw(RunSw), .BrkEn(BrkEn),
        .BrkAddr(BrkAddr), .Adds(Adds), .WEin(WEin), .PCEn(pcen[0]), .WEout(we[0]),
        .State(st[0]), .Halted(halt[0]), .InstCount(cnt[0]));
    exec_ctrl #(.DEB_CYCLES(16), .RUN_DIV(3), .ADDR_W(16)) u_d3 (
        .clk(clk), .Reset(Reset), .StepKey(StepKey), .RunSw(RunSw), .BrkEn(BrkEn),
        .BrkAddr(BrkAddr), .Adds(Adds), .WEin(WEin), .PCEn(pcen[1]), .WEout(we[1]),
        .State(st[1]), .Halted(halt[1]), .InstCount(cnt[1]));
    exec_ctrl #(.DEB_CYCLES(16), .RUN_DIV(1), .ADDR_W(16)) u_d1 (
        .clk(clk), .Reset(Reset), .StepKey(StepKey), .RunSw(RunSw), .BrkEn(BrkEn),
        .BrkAddr(BrkAddr), .Adds(Adds), .WEin(WEin), .PCEn(pcen[2]), .WEout(we[2]),
        .State(st[2]), .Halted(halt[2]), .InstCount(cnt[2]));

    function automatic int div_of(int k);
        return (k == 0) ? 4 : ((k == 1) ? 3 : 1);
    endfunction

    function automatic logic m_pcen(int k);
        return m_run[k] && RunSw && ((m_age[k] % div_of(k)) == div_of(k) - 1);
    endfunction

    // {State, Halted, PCEn, WEout, InstCount}
    function automatic logic [20:0] exp_vec(int k);
        logic p;
        p = m_pcen(k);
        return {(m_run[k] ? 2'b01 : 2'b00), !m_run[k], p, WEin & p, 16'(m_cnt[k])};
    endfunction

    function automatic logic [20:0] act_vec(int k);
        return {st[k], halt[k], pcen[k], we[k], cnt[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_run[k] = 0; m_age[k] = 0; m_cnt[k] = 0;
        end
    endtask

    // Advance the model across the coming clock edge using current inputs.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            if (Reset) begin
                m_run[k] = 0; m_age[k] = 0; m_cnt[k] = 0;
            end else if (m_run[k]) begin
                if (!RunSw) m_run[k] = 0;
                else begin
                    if (m_pcen(k)) m_cnt[k] = m_cnt[k] + 1;
                    m_age[k] = m_age[k] + 1;
                end
            end else if (RunSw) begin
                m_run[k] = 1; m_age[k] = 0;
            end
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(negedge clk);
        model_step();
        next_cyc();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        RunSw = 1'b1; Reset = 1'b1; StepKey = 1'b1; WEin = 1'b0;
        model_reset();
        next_cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (act_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL reset_hold dut=%0d got %h exp %h", k, act_vec(k), exp_vec(k));
                end
            end
            if (i == 2) Reset = 1'b0;
            model_step();
            next_cyc();
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (act_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL reset_run dut=%0d cyc=%0d got %h exp %h", k, i, act_vec(k), exp_vec(k));
                end
            end
            model_step();
            next_cyc();
        end
        @(negedge clk);
        n_tests++;
        if (cnt[0] !== 16'd5) begin
            n_fail++;
            $display("FAIL run20_count got %0d exp 5", cnt[0]);
        end
        next_cyc();
    endtask

    task automatic test_step();
        int q[$];
        int steps [3];
        int pulses[3];
        int wes   [3];
        int c0    [3];
        do_reset();
        RunSw = 1'b0; WEin = 1'b1;
        for (int i = 0; i < 5; i++) next_cyc();
        for (int k = 0; k < 3; k++) begin
            steps[k] = 0; pulses[k] = 0; wes[k] = 0; c0[k] = int'(cnt[k]);
        end
        // bouncy press, long hold, bouncy release, long idle
        for (int b = 0; b < 3; b++) begin
            for (int j = $urandom_range(1, 3); j > 0; j--) q.push_back(0);
            for (int j = $urandom_range(1, 3); j > 0; j--) q.push_back(1);
        end
        for (int j = 0; j < 40; j++) q.push_back(0);
        for (int b = 0; b < 3; b++) begin
            for (int j = $urandom_range(1, 3); j > 0; j--) q.push_back(1);
            for (int j = $urandom_range(1, 3); j > 0; j--) q.push_back(0);
        end
        for (int j = 0; j < 40; j++) q.push_back(1);
        foreach (q[i]) begin
            StepKey = q[i][0];
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (st[k] == 2'b10) steps[k]++;
                if (pcen[k]) pulses[k]++;
                if (we[k]) wes[k]++;
            end
            next_cyc();
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if ({steps[k], pulses[k], wes[k], int'(cnt[k]) - c0[k]} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
                n_fail++;
                $display("FAIL step_once dut=%0d steps=%0d pcen=%0d we=%0d inc=%0d exp 1 each",
                         k, steps[k], pulses[k], wes[k], int'(cnt[k]) - c0[k]);
            end
        end
        WEin = 1'b0;
        next_cyc();
    endtask

    task automatic test_break();
        int pc = 0;
        int pulses = 0;
        int stray = 0;
        bit hit = 0;
        bit got = 0;
        do_reset();
        BrkEn = 1'b1; BrkAddr = 16'h0005; Adds = 16'h0; RunSw = 1'b1; StepKey = 1'b1;
        for (int i = 0; i < 60 && !hit; i++) begin
            Adds = 16'(pc);
            @(negedge clk);
            if (st[0] == 2'b11) hit = 1;
            else if (pcen[0]) begin pulses++; pc++; end
            if (!hit) next_cyc();
        end
        n_tests++;
        if (!hit || pulses != 5 || pc != 5 || halt[0] !== 1'b1 || pcen[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL brk_entry hit=%0d pulses=%0d pc=%0d halted=%b pcen=%b exp 1/5/5/1/0",
                     hit, pulses, pc, halt[0], pcen[0]);
        end
        for (int i = 0; i < 8; i++) begin
            next_cyc();
            @(negedge clk);
            if (pcen[0] || st[0] != 2'b11) stray++;
        end
        n_tests++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL brk_hold bad_cycles=%0d exp 0", stray);
        end
        for (int i = 0; i < 60 && !got; i++) begin
            next_cyc();
            StepKey = 1'b0;
            @(negedge clk);
            if (st[0] == 2'b10) got = 1;
            else if (pcen[0]) stray++;
        end
        n_tests++;
        if (!got || pcen[0] !== 1'b1 || stray != 0 || Adds !== 16'h0005) begin
            n_fail++;
            $display("FAIL brk_step got=%0d pcen=%b stray=%0d pc=%h exp 1/1/0/0005", got, pcen[0], stray, Adds);
        end
        if (pcen[0]) pc++;
        next_cyc();
        Adds = 16'(pc);
        @(negedge clk);
        n_tests++;
        if ({st[0], pcen[0]} !== 3'b000) begin
            n_fail++;
            $display("FAIL brk_after_step state=%b pcen=%b exp 00/0", st[0], pcen[0]);
        end
        next_cyc();
        StepKey = 1'b1;
        @(negedge clk);
        n_tests++;
        if (st[0] !== 2'b01 || Adds !== 16'h0006) begin
            n_fail++;
            $display("FAIL brk_resume state=%b pc=%h exp 01/0006", st[0], Adds);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            next_cyc();
            Adds = 16'(pc);
            @(negedge clk);
            if (pcen[0]) begin pulses++; pc++; end
        end
        n_tests++;
        if (pulses != 3 || st[0] !== 2'b01) begin
            n_fail++;
            $display("FAIL brk_rerun pulses=%0d state=%b exp 3/01", pulses, st[0]);
        end
        BrkEn = 1'b0; Adds = 16'h0;
        next_cyc();
    endtask

    task automatic test_we();
        int we1 = 0;
        int we2 = 0;
        do_reset();
        RunSw = 1'b1; WEin = 1'b1;
        for (int i = 0; i < 33; i++) begin
            if (i >= 13) WEin = 1'($urandom);
            @(negedge clk);
            if (i < 13) begin
                if (we[1]) we1++;
                if (we[2]) we2++;
            end
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (act_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL we_gate dut=%0d cyc=%0d got %h exp %h", k, i, act_vec(k), exp_vec(k));
                end
            end
            model_step();
            next_cyc();
        end
        n_tests++;
        if (we1 != 4 || we2 != 12) begin
            n_fail++;
            $display("FAIL we_rate div3=%0d div1=%0d exp 4/12", we1, we2);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            Reset = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 5) == 0) RunSw = ~RunSw;
            WEin = 1'($urandom);
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (act_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL random dut=%0d cyc=%0d got %h exp %h", k, i, act_vec(k), exp_vec(k));
                end
            end
            model_step();
            next_cyc();
        end
        Reset = 1'b0;
    endtask

    task automatic test_wrap();
        int guard = 0;
        do_reset();
        RunSw = 1'b1; WEin = 1'b0;
        while (m_cnt[2] != 65534 && guard < 70000) begin
            @(negedge clk);
            model_step();
            next_cyc();
            guard++;
        end
        @(negedge clk);
        n_tests++;
        if (cnt[2] !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL wrap_preload got %h exp fffe", cnt[2]);
        end
        for (int i = 0; i < 3; i++) begin
            model_step();
            next_cyc();
            @(negedge clk);
        end
        n_tests++;
        if (cnt[2] !== 16'h0001) begin
            n_fail++;
            $display("FAIL wrap_count got %h exp 0001", cnt[2]);
        end
        n_tests++;
        if (act_vec(0) !== exp_vec(0)) begin
            n_fail++;
            $display("FAIL wrap_div4 got %h exp %h", act_vec(0), exp_vec(0));
        end
        next_cyc();
    endtask

    task automatic test_reset_mid();
        bit found = 0;
        int extra = 0;
        int steps = 0;
        // reset landing in the STEP cycle, key still held
        do_reset();
        RunSw = 1'b0;
        for (int i = 0; i < 4; i++) next_cyc();
        StepKey = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (st[0] == 2'b10) found = 1;
            else next_cyc();
        end
        Reset = 1'b1;
        next_cyc();
        Reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (!found || st[0] !== 2'b00 || cnt[0] !== 16'd0 || pcen[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_step found=%0d state=%b cnt=%0d pcen=%b exp 1/00/0/0", found, st[0], cnt[0], pcen[0]);
        end
        for (int i = 0; i < 40; i++) begin
            next_cyc();
            @(negedge clk);
            if (st[0] == 2'b10 || pcen[0]) extra++;
        end
        n_tests++;
        if (extra != 0) begin
            n_fail++;
            $display("FAIL held_key_after_rst pulses=%0d exp 0", extra);
        end
        for (int i = 0; i < 60; i++) begin
            next_cyc();
            StepKey = (i < 30);
            @(negedge clk);
            if (st[0] == 2'b10) steps++;
        end
        n_tests++;
        if (steps != 1) begin
            n_fail++;
            $display("FAIL repress_after_rst steps=%0d exp 1", steps);
        end
        next_cyc();
        StepKey = 1'b1;
        for (int i = 0; i < 25; i++) next_cyc();
        // reset landing in a RUN issue cycle
        do_reset();
        RunSw = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (pcen[0]) found = 1;
            else next_cyc();
        end
        Reset = 1'b1;
        next_cyc();
        Reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (!found || st[0] !== 2'b00 || cnt[0] !== 16'd0 || pcen[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_in_issue found=%0d state=%b cnt=%0d pcen=%b exp 1/00/0/0", found, st[0], cnt[0], pcen[0]);
        end
        model_reset();
        model_step();
        next_cyc();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (act_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL rst_div_restart dut=%0d cyc=%0d got %h exp %h", k, i, act_vec(k), exp_vec(k));
                end
            end
            model_step();
            next_cyc();
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_break();
        test_we();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
